fix2fp_norm: RTL and testbench

Pipelined fixed-to-float normaliser that converts signed two's-complement fixed-point samples into the team's (sign, signed exponent, explicit-leading-one fraction) float format. It sits directly upstream of the FMUL multiplier and supplies its operands. The normaliser takes the datapath's fixed-point angle and coefficient words, and produces the normalised (sign, exp, frac) triples that FMUL expects. It has a three-stage valid/ready pipeline and sustains one sample per cycle.

---
 rtl/fp_pkg.sv | 11 +
 rtl/lzc_norm.sv | 16 +
 rtl/fix2fp_norm.sv | 84 ++++++++
 tb/tb_fix2fp_norm.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared float-format constants and the {sign, exp, frac} triple type
package fp_pkg;
  localparam int FRAC_WIDTH_D = 40;
  localparam int EXP_WIDTH_D = 8;
  localparam logic [EXP_WIDTH_D-1:0] EXP_ZERO = {1'b1, {(EXP_WIDTH_D-1){1'b0}}};
  typedef struct packed {
    logic sign;
    logic [EXP_WIDTH_D-1:0] exp;
    logic [FRAC_WIDTH_D-1:0] frac;
  } fp_t;
endpackage

// File: rtl/lzc_norm.sv
// lzc_norm: combinational leading-one position and all-zero flag
module lzc_norm #(
  parameter int W = 32,
  parameter int PW = $clog2(W)
) (
  input  logic [W-1:0]  i_data,
  output logic [PW-1:0] o_pos,
  output logic          o_zero
);
  // highest set bit wins because later iterations overwrite earlier ones
  always_comb begin
    o_pos = '0;
    for (int i = 0; i < W; i++) if (i_data[i]) o_pos = PW'(i);
  end
  assign o_zero = ~|i_data;
endmodule

// File: rtl/fix2fp_norm.sv
// fix2fp_norm: three-stage valid/ready fixed-point to (sign, exp, frac) normaliser
module fix2fp_norm
  import fp_pkg::*;
#(
  parameter int IN_WIDTH = 32,
  parameter int IN_FRAC = 30,
  parameter int FRAC_WIDTH = FRAC_WIDTH_D,
  parameter int EXP_WIDTH = EXP_WIDTH_D
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [IN_WIDTH-1:0]   i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_sign,
  output logic [EXP_WIDTH-1:0]  o_exp,
  output logic [FRAC_WIDTH-1:0] o_frac
);
  localparam int PW = $clog2(IN_WIDTH);
  localparam int SW = $clog2(FRAC_WIDTH);
  localparam logic [EXP_WIDTH-1:0] L_EXP_ZERO = {1'b1, {(EXP_WIDTH-1){1'b0}}};
  if (IN_WIDTH > FRAC_WIDTH || IN_WIDTH - 1 - IN_FRAC > 2**(EXP_WIDTH-1) - 1 ||
      -IN_FRAC <= -(2**(EXP_WIDTH-1))) begin : g_bad_params
    $error("fix2fp_norm: illegal parameter set");
  end
  logic r_v1, r_v2, r_v3;
  logic w_ld1, w_ld2, w_ld3;
  logic r_s1;
  logic [IN_WIDTH-1:0] r_mag1;
  logic r_s2, r_z2;
  logic [IN_WIDTH-1:0] r_mag2;
  logic [PW-1:0] r_p2;
  logic [EXP_WIDTH-1:0] r_exp2;
  logic [PW-1:0] w_p;
  logic w_z;
  logic [EXP_WIDTH-1:0] w_exp;
  logic [SW-1:0] w_sh;
  logic [FRAC_WIDTH-1:0] w_frac;
  assign w_ld3 = !r_v3 || i_ready;
  assign w_ld2 = !r_v2 || w_ld3;
  assign w_ld1 = !r_v1 || w_ld2;
  assign o_ready = w_ld1;
  assign o_valid = r_v3;
  lzc_norm #(.W(IN_WIDTH)) u_lzc (.i_data(r_mag1), .o_pos(w_p), .o_zero(w_z));
  assign w_exp = EXP_WIDTH'(int'(w_p) - IN_FRAC);
  assign w_sh = SW'(FRAC_WIDTH - 1) - SW'(r_p2);
  assign w_frac = FRAC_WIDTH'(r_mag2) << w_sh;
  // S1/S2 data registers, written only when their stage takes a valid sample
  always_ff @(posedge i_clk) begin
    if (w_ld1 && i_valid) begin
      r_s1 <= i_data[IN_WIDTH-1];
      r_mag1 <= i_data[IN_WIDTH-1] ? -i_data : i_data;
    end
    if (w_ld2 && r_v1) begin
      r_s2 <= r_s1;
      r_mag2 <= r_mag1;
      r_p2 <= w_p;
      r_z2 <= w_z;
      r_exp2 <= w_exp;
    end
  end
  // valid chain and S3 output register; zero input forces the zero encoding
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
      o_sign <= 1'b0;
      o_exp <= L_EXP_ZERO;
      o_frac <= '0;
    end else begin
      if (w_ld1) r_v1 <= i_valid;
      if (w_ld2) r_v2 <= r_v1;
      if (w_ld3) r_v3 <= r_v2;
      if (w_ld3 && r_v2) begin
        o_sign <= r_s2 && !r_z2;
        o_exp <= r_z2 ? L_EXP_ZERO : r_exp2;
        o_frac <= r_z2 ? '0 : w_frac;
      end
    end
  end
endmodule

// File: tb/tb_fix2fp_norm.sv
// tb_fix2fp_norm: directed vectors with a queue scoreboard and decoupled output monitor
module tb_fix2fp_norm;
  logic i_clk = 0, i_rst, i_valid, i_ready, o_ready, o_valid, o_sign;
  logic [31:0] i_data;
  logic [7:0] o_exp;
  logic [39:0] o_frac;
  int checks = 0, failures = 0, cyc = 0;
  typedef struct { logic [48:0] res; bit lc; int c; } exp_t;
  exp_t sb[$];
  logic [31:0] vd[13];
  logic [48:0] ve[13];
  logic [48:0] held;
  bit held_v = 0, seen_nr = 0;

  fix2fp_norm dut (.i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .o_valid(o_valid), .i_ready(i_ready), .o_sign(o_sign),
    .o_exp(o_exp), .o_frac(o_frac));

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] r);
    checks++;
    if (a !== r) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, a, r);
    end
  endtask

  // monitor: checks held outputs during stalls and pops the scoreboard on each transfer
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_valid && !i_ready) begin
        if (held_v) chk("hold", {o_sign, o_exp, o_frac}, held);
        held_v = 1;
        held = {o_sign, o_exp, o_frac};
      end else held_v = 0;
      if (!o_ready) seen_nr = 1;
      if (o_valid && i_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%h required=none", {o_sign, o_exp, o_frac});
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", {o_sign, o_exp, o_frac}, e.res);
          if (e.lc) chk("latency", cyc - e.c, 3);
        end
      end
    end
  end

  task automatic send(input int k, input bit lc);
    i_valid = 1;
    i_data = vd[k];
    for (int t = 0; t < 50; t++) begin
      @(negedge i_clk);
      if (o_ready) begin
        exp_t e;
        e.res = ve[k];
        e.lc = lc;
        e.c = cyc;
        sb.push_back(e);
        @(posedge i_clk);
        #1;
        return;
      end
    end
    chk("accept_timeout", 0, 1);
  endtask

  task automatic idle();
    i_valid = 0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && sb.size() != 0; t++) @(posedge i_clk);
    #1;
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    vd = '{32'h40000000, 32'hA0000000, 32'h80000000, 32'h00000001, 32'h00000000,
           32'h7FFFFFFF, 32'hFFFFFFFF, 32'h20000000, 32'hC0000000, 32'h00000003,
           32'h12345678, 32'hEDCBA988, 32'h00010000};
    ve = '{{1'b0, 8'h00, 40'h8000000000}, {1'b1, 8'h00, 40'hC000000000},
           {1'b1, 8'h01, 40'h8000000000}, {1'b0, 8'hE2, 40'h8000000000},
           {1'b0, 8'h80, 40'h0000000000}, {1'b0, 8'h00, 40'hFFFFFFFE00},
           {1'b1, 8'hE2, 40'h8000000000}, {1'b0, 8'hFF, 40'h8000000000},
           {1'b1, 8'h00, 40'h8000000000}, {1'b0, 8'hE3, 40'hC000000000},
           {1'b0, 8'hFE, 40'h91A2B3C000}, {1'b1, 8'hFE, 40'h91A2B3C000},
           {1'b0, 8'hF2, 40'h8000000000}};
    i_rst = 1; i_valid = 0; i_data = 0; i_ready = 1;
    repeat (3) @(posedge i_clk);
    #1 i_rst = 0;
    @(negedge i_clk);
    chk("reset_valid", o_valid, 0);
    chk("reset_ready", o_ready, 1);
    chk("reset_out", {o_sign, o_exp, o_frac}, {1'b0, 8'h80, 40'h0});
    @(posedge i_clk);
    #1;
    send(0, 1);
    idle();
    drain();
    for (int k = 0; k < 13; k++) send(k, 1);
    idle();
    drain();
    seen_nr = 0;
    fork
      for (int k = 0; k < 16; k++) begin
        i_ready = !(k >= 4 && k <= 7);
        @(posedge i_clk);
        #1;
      end
      begin
        for (int k = 0; k < 10; k++) send(k, 0);
        idle();
      end
    join
    drain();
    chk("o_ready_drop", seen_nr, 1);
    i_ready = 0;
    for (int k = 5; k < 8; k++) send(k, 0);
    i_rst = 1; i_valid = 1; i_data = 32'h40000000;
    @(posedge i_clk);
    #1;
    i_rst = 0; i_valid = 0; i_ready = 1;
    sb.delete();
    @(negedge i_clk);
    chk("rst_mid_valid", o_valid, 0);
    chk("rst_mid_ready", o_ready, 1);
    chk("rst_mid_out", {o_sign, o_exp, o_frac}, {1'b0, 8'h80, 40'h0});
    @(posedge i_clk);
    #1;
    send(8, 1);
    idle();
    drain();
    repeat (5) @(posedge i_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
